// File: rtl/sd_card_pkg.sv
// Shared types and constants for the card-side SD DAT engine.
// Holds the FSM state encoding, the CRC16 polynomial and the CRC status tokens.
package sd_card_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RX_DAT,
        ST_RX_CRC,
        ST_RX_END,
        ST_TURN,
        ST_TX_STAT,
        ST_BUSY,
        ST_RELEASE,
        ST_TX_START,
        ST_TX_DAT,
        ST_TX_CRC,
        ST_TX_END
    } state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [2:0]  STAT_OK    = 3'b010;
    localparam logic [2:0]  STAT_ERR   = 3'b101;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_crc16_serial.sv
// One-bit-per-cycle CRC16 (x^16+x^12+x^5+1, init 0, MSB first); result is visible the cycle after the last enable.
// No backpressure: clear wins over enable, and the register holds its value when idle.
module sd_crc16_serial
    import sd_card_pkg::*;
(
    input  logic        sd_clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = crc16_step(crc_q, bit_i);
        end
    end

    always_ff @(posedge sd_clk) begin
        if (rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_data_serial_card.sv
// Card-side SD 4-bit DAT engine: receives write blocks (CRC status token + DAT0 busy) and transmits read blocks.
// Pad outputs are decoded from registered state; backend backpressure comes only through busy_i stretching DAT0 busy.
module sd_data_serial_card
    import sd_card_pkg::*;
#(
    parameter int SD_BUS_W = 4,
    parameter int BLK_NIB  = 1024,
    parameter int BUSY_MIN = 8
) (
    input  logic                sd_clk,
    input  logic                rst,
    input  logic [SD_BUS_W-1:0] DAT_dat_i,
    output logic [SD_BUS_W-1:0] DAT_dat_o,
    output logic                DAT_oe_o,
    input  logic                start_rd,
    output logic                rd_req_o,
    input  logic [31:0]         rd_data_i,
    output logic                rd_done_o,
    output logic [31:0]         wr_data_o,
    output logic                wr_valid_o,
    output logic                wr_done_o,
    output logic                wr_crc_ok_o,
    input  logic                busy_i
);

    localparam int                  BUSY_W    = $clog2(BUSY_MIN + 1);
    localparam logic [9:0]          LAST_NIB  = 10'(BLK_NIB - 1);
    localparam logic [BUSY_W-1:0]   BUSY_LAST = BUSY_W'(BUSY_MIN - 1);
    localparam logic [SD_BUS_W-1:0] DAT_IDLE  = {SD_BUS_W{1'b1}};
    localparam logic [SD_BUS_W-1:0] DAT_BUSY  = {{(SD_BUS_W-1){1'b1}}, 1'b0};

    state_e              state_q, state_d;
    logic [9:0]          nib_q, nib_d;
    logic [3:0]          crc_cnt_q, crc_cnt_d;
    logic [2:0]          stat_cnt_q, stat_cnt_d;
    logic [BUSY_W-1:0]   busy_cnt_q, busy_cnt_d;
    logic [31:0]         sr_q, sr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                wr_valid_q, wr_valid_d;
    logic                wr_done_q, wr_done_d;
    logic                wr_ok_q, wr_ok_d;

    logic [15:0]         crc_val [SD_BUS_W];
    logic [SD_BUS_W-1:0] crc_msb, crc_in;
    logic                crc_clr, crc_en, crc_zero;
    logic [4:0]          tok_seq;

    // RX and TX never overlap, so one CRC bank per line serves both directions.
    for (genvar g = 0; g < SD_BUS_W; g++) begin : g_crc
        sd_crc16_serial u_crc (
            .sd_clk (sd_clk),
            .rst    (rst),
            .clr_i  (crc_clr),
            .en_i   (crc_en),
            .bit_i  (crc_in[g]),
            .crc_o  (crc_val[g])
        );
        assign crc_msb[g] = crc_val[g][15];
    end

    // Received CRC bits are shifted through the generator; a matching CRC leaves a zero residue.
    always_comb begin
        crc_zero = 1'b1;
        for (int i = 0; i < SD_BUS_W; i++) begin
            if (crc_val[i] != 16'h0000) crc_zero = 1'b0;
        end
    end

    assign tok_seq = {1'b0, (wr_ok_q ? STAT_OK : STAT_ERR), 1'b1};

    always_comb begin
        state_d    = state_q;
        nib_d      = nib_q;
        crc_cnt_d  = crc_cnt_q;
        stat_cnt_d = stat_cnt_q;
        busy_cnt_d = busy_cnt_q;
        sr_d       = sr_q;
        wr_data_d  = wr_data_q;
        wr_valid_d = 1'b0;
        wr_done_d  = 1'b0;
        wr_ok_d    = wr_ok_q;
        DAT_dat_o  = DAT_IDLE;
        DAT_oe_o   = 1'b0;
        rd_req_o   = 1'b0;
        rd_done_o  = 1'b0;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        crc_in     = DAT_dat_i;

        case (state_q)
            ST_IDLE: begin
                crc_clr    = 1'b1;
                nib_d      = '0;
                crc_cnt_d  = '0;
                stat_cnt_d = '0;
                busy_cnt_d = '0;
                if (DAT_dat_i == '0) begin
                    state_d = ST_RX_DAT;
                end else if (start_rd) begin
                    state_d = ST_TX_START;
                end
            end
            ST_RX_DAT: begin
                crc_en    = 1'b1;
                wr_data_d = {wr_data_q[31-SD_BUS_W:0], DAT_dat_i};
                nib_d     = nib_q + 10'd1;
                if (nib_q[2:0] == 3'd7) wr_valid_d = 1'b1;
                if (nib_q == LAST_NIB) begin
                    nib_d   = '0;
                    state_d = ST_RX_CRC;
                end
            end
            ST_RX_CRC: begin
                crc_en    = 1'b1;
                crc_cnt_d = crc_cnt_q + 4'd1;
                if (crc_cnt_q == 4'd15) state_d = ST_RX_END;
            end
            ST_RX_END: begin
                wr_ok_d    = crc_zero && (DAT_dat_i == DAT_IDLE);
                wr_done_d  = 1'b1;
                stat_cnt_d = '0;
                state_d    = ST_TURN;
            end
            ST_TURN: begin
                stat_cnt_d = stat_cnt_q + 3'd1;
                if (stat_cnt_q == 3'd1) begin
                    stat_cnt_d = '0;
                    state_d    = ST_TX_STAT;
                end
            end
            ST_TX_STAT: begin
                DAT_oe_o   = 1'b1;
                DAT_dat_o  = {{(SD_BUS_W-1){1'b1}}, tok_seq[3'd4 - stat_cnt_q]};
                stat_cnt_d = stat_cnt_q + 3'd1;
                if (stat_cnt_q == 3'd4) begin
                    stat_cnt_d = '0;
                    busy_cnt_d = '0;
                    state_d    = wr_ok_q ? ST_BUSY : ST_RELEASE;
                end
            end
            ST_BUSY: begin
                DAT_oe_o  = 1'b1;
                DAT_dat_o = DAT_BUSY;
                if (busy_cnt_q != BUSY_LAST) begin
                    busy_cnt_d = busy_cnt_q + 1'b1;
                end else if (!busy_i) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                DAT_oe_o = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_TX_START: begin
                DAT_oe_o  = 1'b1;
                DAT_dat_o = '0;
                rd_req_o  = 1'b1;
                sr_d      = rd_data_i;
                nib_d     = '0;
                state_d   = ST_TX_DAT;
            end
            ST_TX_DAT: begin
                DAT_oe_o  = 1'b1;
                DAT_dat_o = sr_q[31 -: SD_BUS_W];
                crc_en    = 1'b1;
                crc_in    = sr_q[31 -: SD_BUS_W];
                sr_d      = {sr_q[31-SD_BUS_W:0], {SD_BUS_W{1'b0}}};
                nib_d     = nib_q + 10'd1;
                if (nib_q == LAST_NIB) begin
                    nib_d     = '0;
                    crc_cnt_d = '0;
                    state_d   = ST_TX_CRC;
                end else if (nib_q[2:0] == 3'd7) begin
                    rd_req_o = 1'b1;
                    sr_d     = rd_data_i;
                end
            end
            ST_TX_CRC: begin
                // Feeding the MSB back into itself turns the generator into a plain shifter.
                DAT_oe_o  = 1'b1;
                DAT_dat_o = crc_msb;
                crc_en    = 1'b1;
                crc_in    = crc_msb;
                crc_cnt_d = crc_cnt_q + 4'd1;
                if (crc_cnt_q == 4'd15) state_d = ST_TX_END;
            end
            ST_TX_END: begin
                DAT_oe_o  = 1'b1;
                rd_done_o = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sd_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            nib_q      <= '0;
            crc_cnt_q  <= '0;
            stat_cnt_q <= '0;
            busy_cnt_q <= '0;
            sr_q       <= '0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            wr_ok_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            nib_q      <= nib_d;
            crc_cnt_q  <= crc_cnt_d;
            stat_cnt_q <= stat_cnt_d;
            busy_cnt_q <= busy_cnt_d;
            sr_q       <= sr_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            wr_done_q  <= wr_done_d;
            wr_ok_q    <= wr_ok_d;
        end
    end

    assign wr_data_o   = wr_data_q;
    assign wr_valid_o  = wr_valid_q;
    assign wr_done_o   = wr_done_q;
    assign wr_crc_ok_o = wr_ok_q;

endmodule

// File: tb/tb_sd_data_serial_card.sv
// Directed bench for the card-side SD DAT engine: write blocks with good/bad CRC and busy stretch, a read block, resets.
// Inputs are driven and outputs sampled on the falling edge; expected values come from constants and a bit-serial CRC model.
module tb_sd_data_serial_card;

    logic        sd_clk = 1'b0;
    logic        rst;
    logic [3:0]  DAT_dat_i;
    logic [3:0]  DAT_dat_o;
    logic        DAT_oe_o;
    logic        start_rd;
    logic        rd_req_o;
    logic [31:0] rd_data_i;
    logic        rd_done_o;
    logic [31:0] wr_data_o;
    logic        wr_valid_o;
    logic        wr_done_o;
    logic        wr_crc_ok_o;
    logic        busy_i;

    int n_chk  = 0;
    int n_pass = 0;

    int          n_wv     = 0;
    int          n_wv_bad = 0;
    int          n_wd     = 0;
    int          n_rdreq  = 0;
    int          n_rddone = 0;
    logic        last_ok  = 1'b0;
    logic [31:0] exp_word = 32'h0;

    always #5 sd_clk = ~sd_clk;

    sd_data_serial_card #(
        .SD_BUS_W (4),
        .BLK_NIB  (1024),
        .BUSY_MIN (8)
    ) dut (
        .sd_clk      (sd_clk),
        .rst         (rst),
        .DAT_dat_i   (DAT_dat_i),
        .DAT_dat_o   (DAT_dat_o),
        .DAT_oe_o    (DAT_oe_o),
        .start_rd    (start_rd),
        .rd_req_o    (rd_req_o),
        .rd_data_i   (rd_data_i),
        .rd_done_o   (rd_done_o),
        .wr_data_o   (wr_data_o),
        .wr_valid_o  (wr_valid_o),
        .wr_done_o   (wr_done_o),
        .wr_crc_ok_o (wr_crc_ok_o),
        .busy_i      (busy_i)
    );

    always @(negedge sd_clk) begin
        if (wr_valid_o) begin
            n_wv++;
            if (wr_data_o !== exp_word) n_wv_bad++;
        end
        if (wr_done_o) begin
            n_wd++;
            last_ok = wr_crc_ok_o;
        end
        if (rd_req_o)  n_rdreq++;
        if (rd_done_o) n_rddone++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge sd_clk);
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
        logic [15:0] r;
        r = {c[14:0], 1'b0};
        if (b ^ c[15]) r = r ^ 16'h1021;
        return r;
    endfunction

    // Pad view: {oe, dat} while driven, 5'h0F when released.
    function automatic logic [4:0] pad();
        return DAT_oe_o ? {1'b1, DAT_dat_o} : 5'h0F;
    endfunction

    task automatic send_wr(input logic [31:0] word, input int flip_line, input logic rd_too,
                           input int hold, input logic exp_ok, input string tag);
        logic [15:0] crc [4];
        logic [3:0]  nib;
        logic [4:0]  tok, exp_pad;
        int          wv0, bad0, wd0, rq0, blen;
        for (int i = 0; i < 4; i++) crc[i] = 16'h0;
        for (int w = 0; w < 128; w++) begin
            for (int j = 0; j < 8; j++) begin
                nib = word[31-4*j -: 4];
                for (int i = 0; i < 4; i++) crc[i] = crc_upd(crc[i], nib[i]);
            end
        end
        exp_word = word;
        wv0 = n_wv; bad0 = n_wv_bad; wd0 = n_wd; rq0 = n_rdreq;

        step(); DAT_dat_i = 4'h0; start_rd = rd_too;
        for (int w = 0; w < 128; w++) begin
            for (int j = 0; j < 8; j++) begin
                step(); start_rd = 1'b0; DAT_dat_i = word[31-4*j -: 4];
            end
        end
        for (int b = 0; b < 16; b++) begin
            step();
            for (int i = 0; i < 4; i++) DAT_dat_i[i] = crc[i][15-b] ^ ((i == flip_line) && (b == 3));
        end
        step(); DAT_dat_i = 4'hF;
        busy_i = (hold > 0);

        tok  = exp_ok ? 5'b00101 : 5'b01011;
        blen = exp_ok ? ((hold > 8) ? hold : 8) : 0;
        for (int c = 0; c <= 10 + blen; c++) begin
            step();
            if (c < 2)              exp_pad = 5'h0F;
            else if (c < 7)         exp_pad = {4'b1111, tok[4-(c-2)]};
            else if (c < 7 + blen)  exp_pad = 5'h1E;
            else if (c == 7 + blen) exp_pad = 5'h1F;
            else                    exp_pad = 5'h0F;
            check($sformatf("%s resp c%0d", tag, c), 32'(pad()), 32'(exp_pad));
            busy_i = (hold > 0) && (c < 6 + hold);
        end
        busy_i = 1'b0;
        check({tag, " wr_valid count"}, 32'(n_wv - wv0), 32'd128);
        check({tag, " wr_data errors"}, 32'(n_wv_bad - bad0), 32'd0);
        check({tag, " wr_done count"}, 32'(n_wd - wd0), 32'd1);
        check({tag, " wr_crc_ok"}, 32'(last_ok), 32'(exp_ok));
        check({tag, " rd_req count"}, 32'(n_rdreq - rq0), 32'd0);
    endtask

    task automatic do_read();
        logic [15:0] crc [4];
        logic [31:0] ww;
        logic [3:0]  nib;
        logic        prev;
        int          rq0, dn0, dat_err, crc_err;
        for (int i = 0; i < 4; i++) crc[i] = 16'h0;
        for (int w = 0; w < 128; w++) begin
            ww = 32'(w);
            for (int j = 0; j < 8; j++) begin
                nib = ww[31-4*j -: 4];
                for (int i = 0; i < 4; i++) crc[i] = crc_upd(crc[i], nib[i]);
            end
        end
        rq0 = n_rdreq; dn0 = n_rddone; dat_err = 0; crc_err = 0; prev = 1'b0;
        rd_data_i = 32'h0;
        step(); start_rd = 1'b1;
        for (int c = 0; c <= 1042; c++) begin
            step();
            if (prev) rd_data_i = rd_data_i + 32'd1;
            prev     = rd_req_o;
            start_rd = 1'b0;
            if (c == 0) begin
                check("rd start bit", 32'(pad()), 32'h10);
            end else if (c <= 1024) begin
                ww  = 32'((c - 1) / 8);
                nib = ww[31-4*((c-1)%8) -: 4];
                if (pad() !== {1'b1, nib}) dat_err++;
            end else if (c <= 1040) begin
                for (int i = 0; i < 4; i++) nib[i] = crc[i][15-(c-1025)];
                if (pad() !== {1'b1, nib}) crc_err++;
            end else if (c == 1041) begin
                check("rd end bit", 32'(pad()), 32'h1F);
            end else begin
                check("rd release", 32'(DAT_oe_o), 32'd0);
            end
        end
        check("rd data nibble errors", 32'(dat_err), 32'd0);
        check("rd crc nibble errors", 32'(crc_err), 32'd0);
        check("rd_req count", 32'(n_rdreq - rq0), 32'd128);
        check("rd_done count", 32'(n_rddone - dn0), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        DAT_dat_i = 4'hF;
        start_rd  = 1'b0;
        rd_data_i = 32'h0;
        busy_i    = 1'b0;
        repeat (3) step();
        check("reset oe", 32'(DAT_oe_o), 32'd0);
        check("reset dat", 32'(DAT_dat_o), 32'hF);
        check("reset wr_data", wr_data_o, 32'h0);
        check("reset wr_crc_ok", 32'(wr_crc_ok_o), 32'd0);
        check("reset pulses", 32'({wr_valid_o, wr_done_o, rd_req_o, rd_done_o}), 32'd0);
        rst = 1'b0;

        // Abort a read mid-block with a one-cycle reset.
        step(); start_rd = 1'b1;
        step(); start_rd = 1'b0;
        repeat (100) step();
        check("pre-reset mid tx oe", 32'(DAT_oe_o), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid tx reset oe", 32'(DAT_oe_o), 32'd0);
        check("mid tx reset dat", 32'(DAT_dat_o), 32'hF);
        check("mid tx reset rd_req", 32'(rd_req_o), 32'd0);
        repeat (2) step();

        send_wr(32'h00001010, -1, 1'b0, 0,  1'b1, "wr_ok");
        send_wr(32'h00001010,  2, 1'b0, 0,  1'b0, "wr_crcerr");
        send_wr(32'h00001010, -1, 1'b0, 20, 1'b1, "wr_busy20");
        repeat (2) step();
        do_read();
        repeat (2) step();
        send_wr(32'h00001010, -1, 1'b1, 0,  1'b1, "wr_vs_rd");
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sd_data_serial_card.md
Name: sd_data_serial_card

Overview:
- Card-side (device-end) engine for the SD 4-bit DAT bus, the counterpart of the host data serial path.
- Write direction: receives host data blocks, checks per-line CRC16, returns the CRC status token and holds busy on DAT0.
- Read direction: on request from card logic, transmits a data block with per-line CRC16.
- Sits between the DAT pads (tristate via DAT_oe_o) and the card's block buffer.

Parameters:
- SD_BUS_W, 4, DAT bus width. Only 4 is supported.
- BLK_NIB, 1024, nibbles per block (512 bytes).
- BUSY_MIN, 8, minimum busy cycles driven after the CRC status token.

Ports:
- sd_clk  in  1  SD bus clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- DAT_dat_i  in  SD_BUS_W  DAT lines as seen at the pads.
- DAT_dat_o  out  SD_BUS_W  DAT drive value.
- DAT_oe_o  out  1  pad output enable.
- start_rd  in  1  level; request a read-block transmission.
- rd_req_o  out  1  pulse; consume rd_data_i this cycle.
- rd_data_i  in  32  next word to send; show-ahead, valid whenever rd_req_o is high.
- rd_done_o  out  1  pulse; end bit of the read block sent.
- wr_data_o  out  32  received word.
- wr_valid_o  out  1  pulse; wr_data_o valid.
- wr_done_o  out  1  pulse; received block finished.
- wr_crc_ok_o  out  1  CRC and end-bit result of last block; valid with wr_done_o.
- busy_i  in  1  backend busy; extends the DAT0 busy phase.

Behaviour:
- Reset (sync, takes effect on next posedge; also valid mid-operation): state IDLE, DAT_oe_o=0, DAT_dat_o=4'hF, all pulses 0, wr_data_o=0, wr_crc_ok_o=0, CRC registers 0.
- States: IDLE, RX_DAT, RX_CRC, RX_END, TURN, TX_STAT, BUSY, RELEASE, TX_START, TX_DAT, TX_CRC, TX_END.
- IDLE priority:
  - DAT_dat_i==4'h0 -> RX_DAT.
  - Otherwise start_rd=1 -> TX_START.
  - If both occur in the same cycle, receive wins and start_rd is ignored until the next IDLE.
- RX_DAT:
  - Captures BLK_NIB nibbles; the first nibble fills wr_data_o[31:28].
  - Every 8th nibble, wr_valid_o pulses the same cycle wr_data_o updates.
  - Each line i feeds its own CRC16 (poly 0x1021, init 0, MSB first).
- RX_CRC: 16 cycles; received CRC bits are compared per line.
- RX_END:
  - Expects DAT_dat_i==4'hF.
  - Sets wr_crc_ok_o = all four CRCs match AND end bit correct; wr_done_o pulses.
- TURN: 2 cycles with oe=0.
- TX_STAT: 5 cycles with oe=1, driving DAT0 = 0, s2, s1, s0, 1.
  - Status token is 010 if ok, 101 if error.
  - DAT[3:1] are driven 1.
- BUSY:
  - DAT0=0 for at least BUSY_MIN cycles.
  - Stays while busy_i=1.
  - Busy is skipped entirely on CRC error: go directly to RELEASE.
- RELEASE: 1 cycle driving 4'hF, then oe=0 -> IDLE.
- TX_START: 1 cycle with oe=1, DAT=4'h0. rd_req_o pulses in this cycle, loading the first word.
- TX_DAT:
  - Sends BLK_NIB nibbles MSB-first from the shift register.
  - rd_req_o pulses on the cycle the 8th nibble of a word is sent, loading the next word (suppressed after the last word).
  - Total rd_req_o pulses per block = 128.
- TX_CRC: 16 cycles, per-line CRC MSB first.
- TX_END: 1 cycle DAT=4'hF with rd_done_o pulse, then oe=0 -> IDLE.
- Host activity on DAT_dat_i during TX states is ignored; no collision detection.
- Counters: 10-bit nibble counter, 4-bit CRC bit counter, 3-bit status counter, busy counter ceil(log2(BUSY_MIN+1)) bits. No wrap allowed mid-block.

Decomposition:
- Package sd_card_pkg: state enum, CRC16_POLY=16'h1021, status tokens STAT_OK=3'b010 and STAT_ERR=3'b101.
- Sub-module sd_crc16_serial (1-bit serial CRC16 with clear and enable), instantiated 4 times, shared between RX and TX since the directions are exclusive.

Test Plan:
- Reset mid-TX_DAT (rst high 1 cycle) -> next cycle oe=0, DAT_dat_o=4'hF, IDLE; a subsequent write block is received normally.
- Write block of words 32'h00001010 repeated with correct CRCs and end bit 4'hF -> 128 wr_valid_o pulses each with 32'h00001010; wr_crc_ok_o=1; after 2 TURN cycles DAT0 = 0,0,1,0,1; then exactly 8 busy cycles with busy_i=0; then 4'hF, then oe=0.
- Same block with one CRC bit flipped on DAT2 -> wr_crc_ok_o=0; token 0,1,0,1,1; no busy cycles.
- Write with busy_i held high 20 cycles past the token -> DAT0 low for 20 cycles until busy_i falls.
- start_rd with rd_data_i = word index (0..127) -> DAT sequence 4'h0, 1024 nibbles, 16 CRC cycles matching the golden model, 4'hF; rd_req_o pulses 128 times; rd_done_o pulses once.
- DAT_dat_i==0 and start_rd asserted in the same IDLE cycle -> receive path taken and no rd_req_o pulse.
